// File: rtl/floo_addr_decode_pkg.sv
// Shared types and constants for the rule-table address/ID decoder.
// Rule templates use 8-bit addresses and indices; wider maps pass their own rule_t.
package floo_addr_decode_pkg;

    localparam int unsigned ERR_CNT_W   = 16;
    localparam int unsigned DFLT_ADDR_W = 8;
    localparam int unsigned DFLT_IDX_W  = 8;

    typedef logic [DFLT_ADDR_W-1:0] dflt_addr_t;

    typedef struct packed {
        logic [DFLT_IDX_W-1:0] idx;
        dflt_addr_t            start_addr;
        dflt_addr_t            end_addr;
    } range_rule_t;

    typedef struct packed {
        logic [DFLT_IDX_W-1:0] idx;
        dflt_addr_t            addr;
        dflt_addr_t            mask;
    } napot_rule_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/floo_addr_decode_rule_match.sv
// Single-rule matcher: range (start <= a < end, end==0 means open-ended) or NAPOT.
// A rule whose index is outside 0..NoIndices-1 never matches.
module floo_addr_rule_match
    import floo_addr_decode_pkg::*;
#(
    parameter int unsigned NoIndices = 32'd2,
    parameter type         addr_t    = dflt_addr_t,
    parameter type         rule_t    = range_rule_t,
    parameter bit          Napot     = 1'b0
) (
    input  addr_t addr_i,
    input  rule_t rule_i,
    output logic  match_o
);

    logic hit;
    logic idx_ok;

    assign idx_ok = (32'(rule_i.idx) < NoIndices);

    if (Napot) begin : g_napot
        assign hit = ((addr_i & rule_i.mask) == (rule_i.addr & rule_i.mask));
    end else begin : g_range
        assign hit = (addr_i >= rule_i.start_addr) &&
                     ((addr_i < rule_i.end_addr) || (rule_i.end_addr == '0));
    end

    assign match_o = hit && idx_ok;

endmodule

// File: rtl/floo_addr_decode.sv
// Rule-table address/ID decoder with a saturating decode-error counter.
// Define ADDR_DECODE_OUT_REG_EN to register idx_o/dec_valid_o/dec_error_o (latency 1).
module floo_addr_decode
    import floo_addr_decode_pkg::*;
#(
    parameter int unsigned NoIndices = 32'd2,
    parameter int unsigned NoRules   = 32'd1,
    parameter type         addr_t    = dflt_addr_t,
    parameter type         rule_t    = range_rule_t,
    parameter bit          Napot     = 1'b0,
    parameter int unsigned IdxWidth  = (NoIndices > 32'd1) ? $clog2(NoIndices) : 32'd1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  addr_t                 addr_i,
    input  rule_t [NoRules-1:0]   addr_map_i,
    input  logic [IdxWidth-1:0]   default_idx_i,
    input  logic                  en_default_idx_i,
    input  logic                  addr_valid_i,
    output logic [IdxWidth-1:0]   idx_o,
    output logic                  dec_valid_o,
    output logic                  dec_error_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    if (NoRules == 0) begin : g_no_rules
        $fatal(1, "floo_addr_decode: NoRules must be at least 1");
    end
    if (NoIndices == 0) begin : g_no_indices
        $fatal(1, "floo_addr_decode: NoIndices must be at least 1");
    end

    logic [NoRules-1:0]   match;
    logic                 hit;
    logic [IdxWidth-1:0]  hit_idx;
    logic [IdxWidth-1:0]  dec_idx_d;
    logic                 dec_valid_d;
    logic                 dec_error_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    for (genvar i = 0; i < NoRules; i++) begin : g_rule
        floo_addr_rule_match #(
            .NoIndices (NoIndices),
            .addr_t    (addr_t),
            .rule_t    (rule_t),
            .Napot     (Napot)
        ) u_match (
            .addr_i  (addr_i),
            .rule_i  (addr_map_i[i]),
            .match_o (match[i])
        );
    end

    // Ascending scan so the highest-numbered matching rule overwrites earlier ones
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned r = 0; r < NoRules; r++) begin
            if (match[r]) begin
                hit     = 1'b1;
                hit_idx = IdxWidth'(addr_map_i[r].idx);
            end
        end
    end

    always_comb begin
        dec_idx_d   = '0;
        dec_valid_d = 1'b0;
        dec_error_d = 1'b0;
        if (hit) begin
            dec_idx_d   = hit_idx;
            dec_valid_d = 1'b1;
        end else if (en_default_idx_i) begin
            dec_idx_d   = default_idx_i;
        end else begin
            dec_error_d = 1'b1;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (addr_valid_i && dec_error_d) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;

`ifdef ADDR_DECODE_OUT_REG_EN
    logic [IdxWidth-1:0] dec_idx_q;
    logic                dec_valid_q;
    logic                dec_error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_idx_q   <= '0;
            dec_valid_q <= 1'b0;
            dec_error_q <= 1'b0;
        end else begin
            dec_idx_q   <= dec_idx_d;
            dec_valid_q <= dec_valid_d;
            dec_error_q <= dec_error_d;
        end
    end

    assign idx_o       = dec_idx_q;
    assign dec_valid_o = dec_valid_q;
    assign dec_error_o = dec_error_q;
`else
    assign idx_o       = dec_idx_d;
    assign dec_valid_o = dec_valid_d;
    assign dec_error_o = dec_error_d;
`endif

endmodule

// File: tb/tb_floo_addr_decode.sv
// Scoreboard bench for floo_addr_decode: one range-mode and one NAPOT-mode instance
// share the same address stream; expectations come from a table-scan reference model.
module tb_floo_addr_decode;
    import floo_addr_decode_pkg::*;

    localparam int NI  = 4;
    localparam int NRR = 4;
    localparam int NRN = 2;
`ifdef ADDR_DECODE_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  addr;
    logic [1:0]  def_idx;
    logic        en_def;
    logic        addr_valid;
    range_rule_t [NRR-1:0] rmap;
    napot_rule_t [NRN-1:0] nmap;
    logic [1:0]  r_idx, n_idx;
    logic        r_valid, r_err, n_valid, n_err;
    logic [15:0] r_cnt, n_cnt;

    floo_addr_decode #(
        .NoIndices (NI),
        .NoRules   (NRR),
        .addr_t    (dflt_addr_t),
        .rule_t    (range_rule_t),
        .Napot     (1'b0)
    ) dut_r (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .addr_i           (addr),
        .addr_map_i       (rmap),
        .default_idx_i    (def_idx),
        .en_default_idx_i (en_def),
        .addr_valid_i     (addr_valid),
        .idx_o            (r_idx),
        .dec_valid_o      (r_valid),
        .dec_error_o      (r_err),
        .err_cnt_o        (r_cnt)
    );

    floo_addr_decode #(
        .NoIndices (NI),
        .NoRules   (NRN),
        .addr_t    (dflt_addr_t),
        .rule_t    (napot_rule_t),
        .Napot     (1'b1)
    ) dut_n (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .addr_i           (addr),
        .addr_map_i       (nmap),
        .default_idx_i    (def_idx),
        .en_default_idx_i (en_def),
        .addr_valid_i     (addr_valid),
        .idx_o            (n_idx),
        .dec_valid_o      (n_valid),
        .dec_error_o      (n_err),
        .err_cnt_o        (n_cnt)
    );

    // Reference tables: pending (being edited) and live (currently on the DUT ports)
    int pr_idx[NRR], pr_lo[NRR], pr_hi[NRR];
    int lr_idx[NRR], lr_lo[NRR], lr_hi[NRR];
    int pn_idx[NRN], pn_base[NRN], pn_mask[NRN];
    int ln_idx[NRN], ln_base[NRN], ln_mask[NRN];

    typedef struct {
        int due;
        int ri, rv, re;
        int ni, nv, ne;
    } exp_t;
    typedef struct {
        int due;
        int val;
    } cexp_t;

    exp_t  q[$];
    cexp_t cq[$];
    int    cyc = 0;
    int    mcnt_r = 0;
    int    mcnt_n = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    bit    finish_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scan from the last rule down: the first hit found is the winner.
    function automatic void look_range(input int a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int r = NRR - 1; r >= 0; r--) begin
            if (lr_idx[r] < NI && a >= lr_lo[r] && (a < lr_hi[r] || lr_hi[r] == 0)) begin
                hit = 1'b1;
                idx = lr_idx[r];
                return;
            end
        end
    endfunction

    function automatic void look_napot(input int a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int r = NRN - 1; r >= 0; r--) begin
            if (ln_idx[r] < NI && (a & ln_mask[r]) == (ln_base[r] & ln_mask[r])) begin
                hit = 1'b1;
                idx = ln_idx[r];
                return;
            end
        end
    endfunction

    function automatic void outcome(input bit hit, input int hidx, output int idx,
                                    output int v, output int e);
        if (hit) begin
            idx = hidx; v = 1; e = 0;
        end else if (en_def) begin
            idx = int'(def_idx); v = 0; e = 0;
        end else begin
            idx = 0; v = 0; e = 1;
        end
    endfunction

    function automatic int sat(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    task automatic set_r(input int i, input int idx, input int lo, input int hi);
        pr_idx[i] = idx; pr_lo[i] = lo; pr_hi[i] = hi;
    endtask

    task automatic set_n(input int i, input int idx, input int base, input int mask);
        pn_idx[i] = idx; pn_base[i] = base; pn_mask[i] = mask;
    endtask

    task automatic drive(input int a, input bit v, input bit en, input int d);
        exp_t e;
        bit   h;
        int   hi, i0, v0, e0;
        @(posedge clk);
        // Error counting uses the inputs that were held across this edge
        if (rst_n && addr_valid) begin
            look_range(int'(addr), h, hi);
            outcome(h, hi, i0, v0, e0);
            if (e0 == 1) mcnt_r = sat(mcnt_r);
            look_napot(int'(addr), h, hi);
            outcome(h, hi, i0, v0, e0);
            if (e0 == 1) mcnt_n = sat(mcnt_n);
        end
        #1;
        for (int r = 0; r < NRR; r++) begin
            lr_idx[r] = pr_idx[r]; lr_lo[r] = pr_lo[r]; lr_hi[r] = pr_hi[r];
            rmap[r].idx = 8'(pr_idx[r]);
            rmap[r].start_addr = 8'(pr_lo[r]);
            rmap[r].end_addr = 8'(pr_hi[r]);
        end
        for (int r = 0; r < NRN; r++) begin
            ln_idx[r] = pn_idx[r]; ln_base[r] = pn_base[r]; ln_mask[r] = pn_mask[r];
            nmap[r].idx = 8'(pn_idx[r]);
            nmap[r].addr = 8'(pn_base[r]);
            nmap[r].mask = 8'(pn_mask[r]);
        end
        addr = 8'(a);
        addr_valid = v;
        en_def = en;
        def_idx = 2'(d);
        look_range(a, h, hi);
        outcome(h, hi, e.ri, e.rv, e.re);
        look_napot(a, h, hi);
        outcome(h, hi, e.ni, e.nv, e.ne);
        e.due = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic drain();
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic pulse_reset();
        cexp_t c;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mcnt_r = 0;
        mcnt_n = 0;
        c.due = cyc;
        c.val = 0;
        cq.push_back(c);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic push_cnt(input int val);
        cexp_t c;
        c.due = cyc;
        c.val = val;
        cq.push_back(c);
    endtask

    function automatic void chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    endfunction

    always @(negedge clk) begin
        exp_t  e;
        cexp_t c;
        chk("r_err_cnt", int'(r_cnt), mcnt_r);
        chk("n_err_cnt", int'(n_cnt), mcnt_n);
`ifdef ADDR_DECODE_OUT_REG_EN
        if (!rst_n) begin
            chk("r_rst_outs", int'({r_idx, r_valid, r_err}), 0);
            chk("n_rst_outs", int'({n_idx, n_valid, n_err}), 0);
        end
`endif
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("stale_item", e.due, cyc);
            chk("r_idx", int'(r_idx), e.ri);
            chk("r_valid", int'(r_valid), e.rv);
            chk("r_error", int'(r_err), e.re);
            chk("n_idx", int'(n_idx), e.ni);
            chk("n_valid", int'(n_valid), e.nv);
            chk("n_error", int'(n_err), e.ne);
        end
        while (cq.size() > 0 && cq[0].due <= cyc) begin
            c = cq.pop_front();
            chk("r_cnt_directed", int'(r_cnt), c.val);
        end
        if (finish_req) begin
            chk("unserviced_items", q.size() + cq.size(), 0);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int mlist[10];
        mlist = '{0, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h0F};
        addr = '0; def_idx = '0; en_def = 1'b0; addr_valid = 1'b0;
        rmap = '0; nmap = '0;
        for (int r = 0; r < NRR; r++) begin
            set_r(r, 0, 0, 0);
            lr_idx[r] = 0; lr_lo[r] = 0; lr_hi[r] = 0;
        end
        for (int r = 0; r < NRN; r++) begin
            set_n(r, 0, 0, 0);
            ln_idx[r] = 0; ln_base[r] = 0; ln_mask[r] = 0;
        end
        #12 rst_n = 1'b1;

        // Table A: adjacent ranges, an open-ended top range and an empty range
        set_r(0, 0, 8'h00, 8'h10);
        set_r(1, 1, 8'h10, 8'h20);
        set_r(2, 2, 8'hF0, 8'h00);
        set_r(3, 3, 8'h20, 8'h20);
        set_n(0, 2, 8'h00, 8'hF0);
        set_n(1, 1, 8'h40, 8'hC0);
        drive(8'h15, 0, 0, 0);
        drive(8'h10, 0, 0, 0);
        drive(8'h0F, 0, 0, 0);
        drive(8'hFF, 0, 0, 0);
        drive(8'h7F, 0, 0, 0);
        drive(8'h05, 0, 1, 1);
        drive(8'h80, 0, 1, 3);
        drive(8'h80, 0, 0, 3);

        // Five qualified misses, then a directed count check
        repeat (5) drive(8'h80, 1, 0, 0);
        drive(8'h80, 0, 0, 0);
        push_cnt(5);
        repeat (3) drive(8'h80, 1, 0, 2);
        drive(8'h15, 0, 0, 0);
        drain();
        pulse_reset();

        // Table B: overlap (last wins), an out-of-range index rule, a one-address range
        set_r(0, 0, 8'h00, 8'h40);
        set_r(1, 2, 8'h20, 8'h30);
        set_r(2, 5, 8'h00, 8'h00);
        set_r(3, 1, 8'h60, 8'h61);
        drive(8'h25, 1, 0, 0);
        drive(8'h35, 1, 0, 0);
        drive(8'h60, 1, 0, 0);
        drive(8'h61, 1, 0, 0);
        drive(8'h80, 1, 1, 2);
        drive(8'h80, 1, 0, 2);

        for (int t = 0; t < 400; t++) begin
            if (t % 25 == 0) begin
                for (int r = 0; r < NRR; r++) begin
                    set_r(r, $urandom_range(0, 5), $urandom_range(0, 255),
                          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255));
                end
                for (int r = 0; r < NRN; r++) begin
                    set_n(r, $urandom_range(0, 5), $urandom_range(0, 255),
                          mlist[$urandom_range(0, 9)]);
                end
            end
            drive($urandom_range(0, 255), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Saturation: hold the counters at all-ones across an edge, then keep missing
        drive(8'h00, 0, 0, 0);
        drain();
        #1;
        force dut_r.err_cnt_q = 16'hFFFF;
        force dut_n.err_cnt_q = 16'hFFFF;
        mcnt_r = 65535;
        mcnt_n = 65535;
        @(negedge clk);
        #1;
        release dut_r.err_cnt_q;
        release dut_n.err_cnt_q;
        for (int r = 0; r < NRR; r++) set_r(r, 7, 0, 0);
        for (int r = 0; r < NRN; r++) set_n(r, 7, 0, 0);
        repeat (4) drive($urandom_range(0, 255), 1, 0, 0);
        drive(8'h00, 0, 0, 0);
        push_cnt(65535);

        drain();
        repeat (2) @(negedge clk);
        finish_req = 1'b1;
    end

endmodule
